// File: rtl/sram_like_arbiter.sv
// Purpose   : shares one SRAM-like master channel between the I-cache, D-cache and
//             uncached (confreg) requesters, tracking ownership of the single
//             outstanding transaction so the response reaches only its owner.
// Latency   : 1 cycle arbitration (IDLE), then ADDR until m_addr_ok, then DATA until
//             m_data_ok; minimum 3 cycles, or 2 when m_addr_ok and m_data_ok coincide.
// Backpressure: the winner's fields are latched and held on m_* until m_addr_ok.
//             Losing or late requesters see no addr_ok and keep req high until a
//             later IDLE cycle grants them.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   {i,d,u}_req/wr/size/wen/addr/wdata   requester command fields
//   {i,d,u}_addr_ok/data_ok  handshakes, combinational from m_* gated by owner
//   {i,d,u}_rdata            m_rdata, zeroed unless that requester's data_ok is high
//   m_req/wr/size/wen/addr/wdata         master command, driven from latched fields
//   m_rdata, m_addr_ok, m_data_ok        master response
//   owner                    0 = none, 1 = i, 2 = d, 3 = u
//   timeout                  sticky; DATA wait reached WAIT_MAX cycles
//
// Build option: define ARB_RR_EN for round-robin arbitration (order i -> d -> u -> i,
// starting after the last grant). Without it, fixed priority u > d > i is used.

module sram_like_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int WAIT_MAX = 255
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              i_req,
    input  logic              i_wr,
    input  logic [1:0]        i_size,
    input  logic [3:0]        i_wen,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_addr_ok,
    output logic              i_data_ok,

    input  logic              d_req,
    input  logic              d_wr,
    input  logic [1:0]        d_size,
    input  logic [3:0]        d_wen,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_addr_ok,
    output logic              d_data_ok,

    input  logic              u_req,
    input  logic              u_wr,
    input  logic [1:0]        u_size,
    input  logic [3:0]        u_wen,
    input  logic [ADDR_W-1:0] u_addr,
    input  logic [DATA_W-1:0] u_wdata,
    output logic [DATA_W-1:0] u_rdata,
    output logic              u_addr_ok,
    output logic              u_data_ok,

    output logic              m_req,
    output logic              m_wr,
    output logic [1:0]        m_size,
    output logic [3:0]        m_wen,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              m_addr_ok,
    input  logic              m_data_ok,

    output logic [1:0]        owner,
    output logic              timeout
);

    localparam int CNT_W = $clog2(WAIT_MAX + 1);

    // One extra bit so the incremented count never wraps before the compare.
    localparam logic [CNT_W:0] WAIT_LIM = (CNT_W + 1)'(WAIT_MAX);
    localparam logic [CNT_W:0] CNT_ONE  = {{CNT_W{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2,
        OWN_U    = 2'd3
    } owner_e;

    typedef struct packed {
        logic              wr;
        logic [1:0]        size;
        logic [3:0]        wen;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e           state_q,   state_d;
    owner_e           owner_q,   owner_d;
    req_t             fld_q,     fld_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic             timeout_q, timeout_d;

    // ------------------------------------------------------------------
    // Requester command bundles
    // ------------------------------------------------------------------
    req_t i_fld;
    req_t d_fld;
    req_t u_fld;

    assign i_fld = {i_wr, i_size, i_wen, i_addr, i_wdata};
    assign d_fld = {d_wr, d_size, d_wen, d_addr, d_wdata};
    assign u_fld = {u_wr, u_size, u_wen, u_addr, u_wdata};

    // ------------------------------------------------------------------
    // Arbitration (only consumed in IDLE)
    // ------------------------------------------------------------------
    owner_e win;
    req_t   win_fld;

`ifdef ARB_RR_EN
    owner_e last_grant_q, last_grant_d;

    // The requester following the last grant in i -> d -> u -> i is searched
    // first; the last winner itself comes last, bounding any wait to two
    // other transactions.
    always_comb begin
        win = OWN_NONE;
        case (last_grant_q)
            OWN_D: begin
                if      (u_req) win = OWN_U;
                else if (i_req) win = OWN_I;
                else if (d_req) win = OWN_D;
            end
            OWN_U: begin
                if      (i_req) win = OWN_I;
                else if (d_req) win = OWN_D;
                else if (u_req) win = OWN_U;
            end
            default: begin
                if      (d_req) win = OWN_D;
                else if (u_req) win = OWN_U;
                else if (i_req) win = OWN_I;
            end
        endcase
    end

    always_comb begin
        last_grant_d = last_grant_q;
        if (state_q == ST_IDLE && win != OWN_NONE) begin
            last_grant_d = win;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= OWN_I;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`else
    always_comb begin
        win = OWN_NONE;
        if      (u_req) win = OWN_U;
        else if (d_req) win = OWN_D;
        else if (i_req) win = OWN_I;
    end
`endif

    always_comb begin
        win_fld = '0;
        case (win)
            OWN_I:   win_fld = i_fld;
            OWN_D:   win_fld = d_fld;
            OWN_U:   win_fld = u_fld;
            default: win_fld = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Handshake qualification
    // ------------------------------------------------------------------
    logic addr_hs;
    logic done;

    assign addr_hs = (state_q == ST_ADDR) && m_addr_ok;
    // A data_ok in IDLE (e.g. left over from a transaction abandoned by
    // reset) never qualifies; in ADDR it only counts alongside addr_ok.
    assign done    = m_data_ok && ((state_q == ST_DATA) || addr_hs);

    // ------------------------------------------------------------------
    // DATA wait counter / timeout
    // ------------------------------------------------------------------
    // cnt_q holds the number of DATA cycles already completed, so the current
    // DATA cycle is number cnt_q + 1. The flag rises in the cycle that number
    // reaches WAIT_MAX and is then held by timeout_q until reset.
    logic [CNT_W:0] cnt_inc;
    logic           timeout_hit;

    assign cnt_inc     = {1'b0, cnt_q} + CNT_ONE;
    assign timeout_hit = (state_q == ST_DATA) && (cnt_inc >= WAIT_LIM);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        fld_d     = fld_q;
        cnt_d     = cnt_q;
        timeout_d = timeout_q | timeout_hit;

        case (state_q)
            ST_IDLE: begin
                if (win != OWN_NONE) begin
                    state_d = ST_ADDR;
                    owner_d = win;
                    fld_d   = win_fld;
                end
            end

            ST_ADDR: begin
                if (m_addr_ok) begin
                    if (m_data_ok) begin
                        state_d = ST_IDLE;
                        owner_d = OWN_NONE;
                    end else begin
                        state_d = ST_DATA;
                        cnt_d   = '0;
                    end
                end
            end

            ST_DATA: begin
                // Saturate so a very long wait cannot wrap the count.
                if (cnt_inc <= WAIT_LIM) begin
                    cnt_d = cnt_inc[CNT_W-1:0];
                end
                if (m_data_ok) begin
                    state_d = ST_IDLE;
                    owner_d = OWN_NONE;
                end
            end

            default: begin
                state_d = ST_IDLE;
                owner_d = OWN_NONE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            owner_q   <= OWN_NONE;
            fld_q     <= '0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            fld_q     <= fld_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // Master side comes only from registers: no path from any *_req to m_req.
    assign m_req   = (state_q == ST_ADDR);
    assign m_wr    = fld_q.wr;
    assign m_size  = fld_q.size;
    assign m_wen   = fld_q.wen;
    assign m_addr  = fld_q.addr;
    assign m_wdata = fld_q.wdata;

    assign i_addr_ok = addr_hs && (owner_q == OWN_I);
    assign d_addr_ok = addr_hs && (owner_q == OWN_D);
    assign u_addr_ok = addr_hs && (owner_q == OWN_U);

    assign i_data_ok = done && (owner_q == OWN_I);
    assign d_data_ok = done && (owner_q == OWN_D);
    assign u_data_ok = done && (owner_q == OWN_U);

    assign i_rdata = i_data_ok ? m_rdata : '0;
    assign d_rdata = d_data_ok ? m_rdata : '0;
    assign u_rdata = u_data_ok ? m_rdata : '0;

    assign owner   = owner_q;
    assign timeout = timeout_q | timeout_hit;

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed bench for sram_like_arbiter (WAIT_MAX overridden to 4).
// Inputs change 1 ns after each rising edge; outputs are checked on the falling edge.
// Cycle numbering in each scenario starts at 1 with the IDLE cycle that presents req.

module tb_sram_like_arbiter;

    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 32;
    localparam int WAIT_MAX = 4;

    logic clk = 1'b0;
    logic rst;

    logic i_req, i_wr, d_req, d_wr, u_req, u_wr;
    logic [1:0] i_size, d_size, u_size;
    logic [3:0] i_wen, d_wen, u_wen;
    logic [ADDR_W-1:0] i_addr, d_addr, u_addr;
    logic [DATA_W-1:0] i_wdata, d_wdata, u_wdata;
    logic [DATA_W-1:0] i_rdata, d_rdata, u_rdata;
    logic i_addr_ok, i_data_ok, d_addr_ok, d_data_ok, u_addr_ok, u_data_ok;

    logic m_req, m_wr;
    logic [1:0] m_size;
    logic [3:0] m_wen;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata, m_rdata;
    logic m_addr_ok, m_data_ok;
    logic [1:0] owner;
    logic timeout;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sram_like_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAIT_MAX(WAIT_MAX)
    ) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_wr(i_wr), .i_size(i_size), .i_wen(i_wen), .i_addr(i_addr), .i_wdata(i_wdata),
        .i_rdata(i_rdata), .i_addr_ok(i_addr_ok), .i_data_ok(i_data_ok),
        .d_req(d_req), .d_wr(d_wr), .d_size(d_size), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok),
        .u_req(u_req), .u_wr(u_wr), .u_size(u_size), .u_wen(u_wen), .u_addr(u_addr), .u_wdata(u_wdata),
        .u_rdata(u_rdata), .u_addr_ok(u_addr_ok), .u_data_ok(u_data_ok),
        .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_wen(m_wen), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok),
        .owner(owner), .timeout(timeout)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        i_req = 0; i_wr = 0; i_size = 2'd2; i_wen = 4'h0; i_addr = '0; i_wdata = '0;
        d_req = 0; d_wr = 0; d_size = 2'd2; d_wen = 4'h0; d_addr = '0; d_wdata = '0;
        u_req = 0; u_wr = 0; u_size = 2'd2; u_wen = 4'h0; u_addr = '0; u_wdata = '0;
        m_rdata = '0; m_addr_ok = 0; m_data_ok = 0;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        clear_inputs();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        do_reset();
        // Stray slave activity in IDLE must not leak to any requester.
        m_rdata = 32'h12345678; m_addr_ok = 1; m_data_ok = 1;
        @(negedge clk);
        n_cmp++; if (m_req !== 1'b0) begin n_err++; $display("FAIL reset_m_req: got %b want 0", m_req); end
        n_cmp++; if (owner !== 2'd0) begin n_err++; $display("FAIL reset_owner: got %0d want 0", owner); end
        n_cmp++; if (timeout !== 1'b0) begin n_err++; $display("FAIL reset_timeout: got %b want 0", timeout); end
        n_cmp++; if ({m_wr, m_size, m_wen} !== 7'd0) begin n_err++; $display("FAIL reset_m_ctl: got %h want 0", {m_wr, m_size, m_wen}); end
        n_cmp++; if ({m_addr, m_wdata} !== 64'd0) begin n_err++; $display("FAIL reset_m_addr_wdata: got %h want 0", {m_addr, m_wdata}); end
        n_cmp++; if ({i_addr_ok, d_addr_ok, u_addr_ok, i_data_ok, d_data_ok, u_data_ok} !== 6'd0) begin
            n_err++; $display("FAIL reset_handshakes: got %b want 000000", {i_addr_ok, d_addr_ok, u_addr_ok, i_data_ok, d_data_ok, u_data_ok}); end
        n_cmp++; if ({i_rdata, d_rdata, u_rdata} !== 96'd0) begin n_err++; $display("FAIL reset_rdata: got %h want 0", {i_rdata, d_rdata, u_rdata}); end
        tick();
        clear_inputs();
    endtask

    task automatic test_single_read;
        do_reset();
        // cycle 1: IDLE, request presented
        i_req = 1; i_addr = 32'h1FC00000;
        @(negedge clk);
        n_cmp++; if (m_req !== 1'b0) begin n_err++; $display("FAIL rd_c1_m_req: got %b want 0", m_req); end
        n_cmp++; if (i_addr_ok !== 1'b0) begin n_err++; $display("FAIL rd_c1_addr_ok: got %b want 0", i_addr_ok); end
        tick();
        // cycle 2: ADDR, slave accepts
        m_addr_ok = 1;
        @(negedge clk);
        n_cmp++; if (m_req !== 1'b1) begin n_err++; $display("FAIL rd_c2_m_req: got %b want 1", m_req); end
        n_cmp++; if (m_addr !== 32'h1FC00000) begin n_err++; $display("FAIL rd_c2_m_addr: got %h want 1fc00000", m_addr); end
        n_cmp++; if (owner !== 2'd1) begin n_err++; $display("FAIL rd_c2_owner: got %0d want 1", owner); end
        n_cmp++; if ({i_addr_ok, d_addr_ok, u_addr_ok} !== 3'b100) begin n_err++; $display("FAIL rd_c2_addr_ok: got %b want 100", {i_addr_ok, d_addr_ok, u_addr_ok}); end
        tick();
        // cycle 3: DATA, waiting
        i_req = 0; m_addr_ok = 0;
        @(negedge clk);
        n_cmp++; if ({m_req, i_data_ok} !== 2'b00) begin n_err++; $display("FAIL rd_c3_req_dok: got %b want 00", {m_req, i_data_ok}); end
        tick();
        // cycle 4: DATA, response
        m_data_ok = 1; m_rdata = 32'h3C1A0000;
        @(negedge clk);
        n_cmp++; if (i_data_ok !== 1'b1) begin n_err++; $display("FAIL rd_c4_data_ok: got %b want 1", i_data_ok); end
        n_cmp++; if (i_rdata !== 32'h3C1A0000) begin n_err++; $display("FAIL rd_c4_rdata: got %h want 3c1a0000", i_rdata); end
        n_cmp++; if ({d_data_ok, u_data_ok, d_rdata, u_rdata} !== 66'd0) begin n_err++; $display("FAIL rd_c4_others: got %h want 0", {d_data_ok, u_data_ok, d_rdata, u_rdata}); end
        tick();
        // cycle 5: back in IDLE
        m_data_ok = 0; m_rdata = '0;
        @(negedge clk);
        n_cmp++; if (owner !== 2'd0) begin n_err++; $display("FAIL rd_c5_owner: got %0d want 0", owner); end
        n_cmp++; if (timeout !== 1'b0) begin n_err++; $display("FAIL rd_c5_timeout: got %b want 0", timeout); end
        tick();
    endtask

    task automatic test_simultaneous;
        logic [1:0]  exp_own [3];
        logic [2:0]  want_vec;
        logic [31:0] want_addr;
`ifdef ARB_RR_EN
        exp_own = '{2'd2, 2'd3, 2'd1};
`else
        exp_own = '{2'd3, 2'd2, 2'd1};
`endif
        do_reset();
        i_req = 1; d_req = 1; u_req = 1;
        i_addr = 32'h00001000; d_addr = 32'h00002000; u_addr = 32'h00003000;
        @(negedge clk);
        n_cmp++; if (owner !== 2'd0) begin n_err++; $display("FAIL sim_arb_owner: got %0d want 0", owner); end
        tick();
        for (int k = 0; k < 3; k++) begin
            case (exp_own[k])
                2'd1:    want_vec = 3'b001;
                2'd2:    want_vec = 3'b010;
                default: want_vec = 3'b100;
            endcase
            want_addr = {18'd0, exp_own[k], 12'd0};
            // ADDR
            m_addr_ok = 1;
            @(negedge clk);
            n_cmp++; if (owner !== exp_own[k]) begin n_err++; $display("FAIL sim_owner_%0d: got %0d want %0d", k, owner, exp_own[k]); end
            n_cmp++; if (m_addr !== want_addr) begin n_err++; $display("FAIL sim_m_addr_%0d: got %h want %h", k, m_addr, want_addr); end
            n_cmp++; if ({u_addr_ok, d_addr_ok, i_addr_ok} !== want_vec) begin n_err++; $display("FAIL sim_addr_ok_%0d: got %b want %b", k, {u_addr_ok, d_addr_ok, i_addr_ok}, want_vec); end
            tick();
            // DATA: winner drops req, losers still hold theirs
            m_addr_ok = 0; m_data_ok = 1;
            case (exp_own[k])
                2'd1:    i_req = 0;
                2'd2:    d_req = 0;
                default: u_req = 0;
            endcase
            @(negedge clk);
            n_cmp++; if ({u_data_ok, d_data_ok, i_data_ok} !== want_vec) begin n_err++; $display("FAIL sim_data_ok_%0d: got %b want %b", k, {u_data_ok, d_data_ok, i_data_ok}, want_vec); end
            tick();
            // IDLE
            m_data_ok = 0;
            @(negedge clk);
            n_cmp++; if (owner !== 2'd0) begin n_err++; $display("FAIL sim_idle_owner_%0d: got %0d want 0", k, owner); end
            tick();
        end
    endtask

    task automatic test_write_latch;
        do_reset();
        u_req = 1; u_wr = 1; u_size = 2'd2; u_wen = 4'h3; u_addr = 32'hBFAF8000; u_wdata = 32'hDEADBEEF;
        @(negedge clk);
        tick();
        // ADDR, slave stalls; requester changes its fields
        u_addr = 32'h00001234; u_wdata = 32'h0; u_wen = 4'hF;
        @(negedge clk);
        n_cmp++; if (m_addr !== 32'hBFAF8000) begin n_err++; $display("FAIL wr_stall1_m_addr: got %h want bfaf8000", m_addr); end
        n_cmp++; if ({m_req, m_wr, m_size, m_wen} !== 8'b1_1_10_0011) begin n_err++; $display("FAIL wr_stall1_ctl: got %b want 11100011", {m_req, m_wr, m_size, m_wen}); end
        n_cmp++; if (m_wdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL wr_stall1_wdata: got %h want deadbeef", m_wdata); end
        n_cmp++; if (u_addr_ok !== 1'b0) begin n_err++; $display("FAIL wr_stall1_addr_ok: got %b want 0", u_addr_ok); end
        tick();
        u_addr = 32'h00005678;
        m_addr_ok = 1;
        @(negedge clk);
        n_cmp++; if (m_addr !== 32'hBFAF8000) begin n_err++; $display("FAIL wr_accept_m_addr: got %h want bfaf8000", m_addr); end
        n_cmp++; if (u_addr_ok !== 1'b1) begin n_err++; $display("FAIL wr_accept_addr_ok: got %b want 1", u_addr_ok); end
        tick();
        u_req = 0; m_addr_ok = 0; m_data_ok = 1;
        @(negedge clk);
        n_cmp++; if ({u_data_ok, m_req} !== 2'b10) begin n_err++; $display("FAIL wr_done: got %b want 10", {u_data_ok, m_req}); end
        tick();
        m_data_ok = 0;
    endtask

    task automatic test_combined;
        do_reset();
        d_req = 1; d_addr = 32'h00000040;
        @(negedge clk);
        tick();
        // ADDR with both handshakes at once
        m_addr_ok = 1; m_data_ok = 1; m_rdata = 32'hCAFEF00D;
        @(negedge clk);
        n_cmp++; if ({d_addr_ok, d_data_ok} !== 2'b11) begin n_err++; $display("FAIL comb_d_hs: got %b want 11", {d_addr_ok, d_data_ok}); end
        n_cmp++; if (d_rdata !== 32'hCAFEF00D) begin n_err++; $display("FAIL comb_rdata: got %h want cafef00d", d_rdata); end
        n_cmp++; if ({i_data_ok, u_data_ok} !== 2'b00) begin n_err++; $display("FAIL comb_others: got %b want 00", {i_data_ok, u_data_ok}); end
        tick();
        // Already IDLE: new request from i is arbitrated here
        d_req = 0; m_addr_ok = 0; m_data_ok = 0; m_rdata = '0;
        i_req = 1; i_addr = 32'h00000080;
        @(negedge clk);
        n_cmp++; if ({owner, m_req} !== 3'b000) begin n_err++; $display("FAIL comb_idle: got %b want 000", {owner, m_req}); end
        tick();
        m_addr_ok = 1;
        @(negedge clk);
        n_cmp++; if ({owner, m_req} !== 3'b011) begin n_err++; $display("FAIL comb_next_grant: got %b want 011", {owner, m_req}); end
        n_cmp++; if (m_addr !== 32'h00000080) begin n_err++; $display("FAIL comb_next_addr: got %h want 00000080", m_addr); end
        tick();
        i_req = 0; m_addr_ok = 0; m_data_ok = 1;
        @(negedge clk);
        tick();
        m_data_ok = 0;
    endtask

    task automatic test_reset_mid_data;
        do_reset();
        i_req = 1; i_addr = 32'h00000100;
        @(negedge clk);
        tick();
        m_addr_ok = 1;
        @(negedge clk);
        tick();
        i_req = 0; m_addr_ok = 0;
        @(negedge clk);
        n_cmp++; if (owner !== 2'd1) begin n_err++; $display("FAIL rmd_owner_data: got %0d want 1", owner); end
        tick();
        rst = 1;
        @(negedge clk);
        tick();
        rst = 0; m_data_ok = 1; m_rdata = 32'h55AA55AA;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_cmp++; if ({i_data_ok, d_data_ok, u_data_ok} !== 3'b000) begin n_err++; $display("FAIL rmd_stale_data_ok_%0d: got %b want 000", c, {i_data_ok, d_data_ok, u_data_ok}); end
            n_cmp++; if ({owner, m_req} !== 3'b000) begin n_err++; $display("FAIL rmd_owner_req_%0d: got %b want 000", c, {owner, m_req}); end
            n_cmp++; if (i_rdata !== 32'h0) begin n_err++; $display("FAIL rmd_rdata_%0d: got %h want 0", c, i_rdata); end
            tick();
        end
        m_data_ok = 0; m_rdata = '0;
    endtask

    task automatic test_timeout;
        logic exp_to;
        do_reset();
        i_req = 1; i_addr = 32'h00000200;
        @(negedge clk);
        tick();
        m_addr_ok = 1;
        @(negedge clk);
        tick();
        i_req = 0; m_addr_ok = 0;
        // DATA cycles 1..6 withheld, response on cycle 7
        for (int c = 1; c <= 7; c++) begin
            m_data_ok = (c == 7);
            exp_to = (c >= 4);
            @(negedge clk);
            n_cmp++; if (timeout !== exp_to) begin n_err++; $display("FAIL to_data_cycle_%0d: got %b want %b", c, timeout, exp_to); end
            if (c == 7) begin
                n_cmp++; if (i_data_ok !== 1'b1) begin n_err++; $display("FAIL to_complete: got %b want 1", i_data_ok); end
            end
            tick();
        end
        m_data_ok = 0;
        @(negedge clk);
        n_cmp++; if ({owner, timeout} !== 3'b001) begin n_err++; $display("FAIL to_sticky_idle: got %b want 001", {owner, timeout}); end
        tick();
        do_reset();
        @(negedge clk);
        n_cmp++; if (timeout !== 1'b0) begin n_err++; $display("FAIL to_cleared_by_rst: got %b want 0", timeout); end
        tick();
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_single_read();
        test_simultaneous();
        test_write_latch();
        test_combined();
        test_reset_mid_data();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
